// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory responder.
package imem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  localparam logic [31:0] NopWordDefault = 32'h0000_0000;

  typedef struct packed {
    logic        err;
    logic [29:0] word;
  } decode_t;

  // Word index (before truncation to the array width) plus misaligned/out-of-range flag.
  function automatic decode_t imem_decode(input logic [31:0] addr, input int unsigned addr_w);
    decode_t d;
    d.word = addr[31:2];
    d.err  = (addr[1:0] != 2'b00) || ((addr >> (addr_w + 2)) != 32'd0);
    return d;
  endfunction

endpackage

// File: rtl/imem_array.sv
// Program storage: one synchronous write port, one asynchronous read port, contents never reset.
module imem_array #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [31:0]       i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction-fetch responder with fixed fetch latency and a side program-load port.
// Optional one-entry last-fetch buffer enabled by defining IMEM_LAST_FETCH_BUF_EN.
module instr_mem_responder
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned LATENCY  = 3,
  parameter logic [31:0] NOP_WORD = NopWordDefault
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read,
  input  logic [31:0]       address,
  output logic              busywait,
  output logic [31:0]       instruction,
  output logic              addr_err,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data
);

  localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e            r_state, w_state_d;
  logic [CntW-1:0]   r_cnt;
  logic [ADDR_W-1:0] r_idx;
  logic              r_lat_err;
  logic [31:0]       r_instr;
  logic              r_err;

  decode_t           w_dec;
  logic [ADDR_W-1:0] w_req_idx;
  logic [31:0]       w_rdata;
  logic              w_hit;
  logic [31:0]       w_hit_data;
  logic              w_unused_word;

  assign w_dec         = imem_decode(address, ADDR_W);
  assign w_req_idx     = w_dec.word[ADDR_W-1:0];
  assign w_unused_word = ^w_dec.word;

  imem_array #(
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk    (clk),
    .i_we   (load_en),
    .i_waddr(load_addr),
    .i_wdata(load_data),
    .i_raddr(r_idx),
    .o_rdata(w_rdata)
  );

`ifdef IMEM_LAST_FETCH_BUF_EN
  logic              r_buf_valid;
  logic [ADDR_W-1:0] r_buf_idx;
  logic [31:0]       r_buf_data;

  assign w_hit      = r_buf_valid && !w_dec.err && (w_req_idx == r_buf_idx);
  assign w_hit_data = r_buf_data;

  // A load landing on the completing word makes the captured (old) data stale immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf_valid <= 1'b0;
    end else if (r_state == StBusy && r_cnt == '0 && !r_lat_err) begin
      r_buf_valid <= !(load_en && load_addr == r_idx);
      r_buf_idx   <= r_idx;
      r_buf_data  <= w_rdata;
    end else if (load_en && load_addr == r_buf_idx) begin
      r_buf_valid <= 1'b0;
    end
  end
`else
  assign w_hit      = 1'b0;
  assign w_hit_data = NOP_WORD;
`endif

  always_comb begin
    w_state_d = r_state;
    busywait  = 1'b0;
    unique case (r_state)
      StIdle: begin
        busywait = read && !w_hit;
        if (read) begin
          w_state_d = w_hit ? StDone : StBusy;
        end
      end
      StBusy: begin
        busywait = 1'b1;
        if (r_cnt == '0) begin
          w_state_d = StDone;
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_instr <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (r_state == StIdle && read) begin
        if (w_hit) begin
          r_instr <= w_hit_data;
          r_err   <= 1'b0;
        end else begin
          r_idx     <= w_req_idx;
          r_lat_err <= w_dec.err;
          r_cnt     <= CntW'(LATENCY - 1);
        end
      end else if (r_state == StBusy) begin
        if (r_cnt != '0) begin
          r_cnt <= r_cnt - 1'b1;
        end else begin
          // Async read sees the pre-edge contents, so a same-edge load returns the old word.
          r_instr <= r_lat_err ? NOP_WORD : w_rdata;
          r_err   <= r_lat_err;
        end
      end
    end
  end

  assign instruction = r_instr;
  assign addr_err    = r_err;

endmodule
